// File: rtl/i2c_request_arbiter_pkg.sv
// Shared I2C definitions: bus field widths and the arbiter state encoding.
package i2c_request_arbiter_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/i2c_request_arbiter_rr.sv
// Round-robin priority select: first asserted request strictly after
// last_grant, wrapping around. Purely combinational.
module rr_priority_select #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    // Scan upward from last_grant+1; the first hit wins.
    always_comb begin
        int cand;
        cand  = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single I2C master controller.
// Optional watchdog on the master handshake: define I2C_ARB_TIMEOUT_EN.
// Master fields are driven only from registers latched at grant time.
module i2c_request_arbiter
    import i2c_request_arbiter_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IW             = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [I2C_DATA_W-1:0]         rdata,
    output logic                          busy,
    output logic [I2C_ADDR_W-1:0]         m_addr,
    output logic [I2C_DATA_W-1:0]         m_data_in,
    output logic                          m_rw,
    output logic                          m_enable,
    input  logic [I2C_DATA_W-1:0]         m_data_out,
    input  logic                          m_ready
);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [I2C_ADDR_W-1:0] addr_q, addr_d;
    logic [I2C_DATA_W-1:0] wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
    logic                  sel_valid;
    logic [IW-1:0]         sel_idx;

    rr_priority_select #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (sel_valid),
        .idx        (sel_idx)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    // Set when the transaction ended by watchdog, so DONE reports err instead.
    logic          to_q, to_d;
    logic          expired;
    assign expired = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, field latching and read capture.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        rdata_d      = rdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
        to_d         = to_q;
        cnt_d        = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    idx_d = sel_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel_idx == IW'(i)) begin
                            addr_d  = req_addr[I2C_ADDR_W*i +: I2C_ADDR_W];
                            wdata_d = req_wdata[I2C_DATA_W*i +: I2C_DATA_W];
                            rw_d    = req_rw[i];
                        end
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    to_d = 1'b0;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // m_ready low means the master has taken the command.
                if (!m_ready) begin
                    state_d = ST_BUSY;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (expired) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_BUSY: begin
                if (m_ready) begin
                    if (rw_q) rdata_d = m_data_out;
                    state_d = ST_DONE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (expired) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                last_grant_d = idx_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef I2C_ARB_TIMEOUT_EN
        // Counts cycles spent in one ISSUE/BUSY phase; any state change restarts it.
        if (state_d == state_q && (state_q == ST_ISSUE || state_q == ST_BUSY))
            cnt_d = cnt_q + TW'(1);
`endif
    end

    // State and latched-field registers; reset parks last_grant so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            rdata_q      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            to_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            rdata_q      <= rdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            to_q         <= to_d;
`endif
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    always_comb begin
        done = '0;
        err  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == ST_DONE && idx_q == IW'(i)) begin
`ifdef I2C_ARB_TIMEOUT_EN
                done[i] = !to_q;
                err[i]  = to_q;
`else
                done[i] = 1'b1;
`endif
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign m_enable  = (state_q == ST_ISSUE);
    assign m_addr    = addr_q;
    assign m_data_in = wdata_q;
    assign m_rw      = rw_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Directed bench for i2c_request_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_i2c_request_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [7*N-1:0] req_addr;
    logic [N-1:0]   req_rw;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic [7:0]     rdata;
    logic           busy;
    logic [6:0]     m_addr;
    logic [7:0]     m_data_in;
    logic           m_rw;
    logic           m_enable;
    logic [7:0]     m_data_out;
    logic           m_ready;

    int checks = 0;
    int errors = 0;

    logic [6:0] addr_tab [N] = '{7'h2A, 7'h31, 7'h45, 7'h5F};

    i2c_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_rw     (req_rw),
        .req_wdata  (req_wdata),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_data_out (m_data_out),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_addrs();
        for (int i = 0; i < N; i++) req_addr[7*i +: 7] = addr_tab[i];
    endtask

    // One full handshake from IDLE with req already driven; exp_idx must win.
    task automatic txn(input int exp_idx, input logic [7:0] rd);
        tick();
        chk($sformatf("grant%0d_en", exp_idx), 32'(m_enable), 32'd1);
        chk($sformatf("grant%0d_addr", exp_idx), 32'(m_addr), 32'(addr_tab[exp_idx]));
        m_ready = 1'b0;
        tick();
        chk("busy_en_low", 32'(m_enable), 32'd0);
        m_ready    = 1'b1;
        m_data_out = rd;
        tick();
        chk($sformatf("done%0d", exp_idx), 32'(done), 32'(1 << exp_idx));
        chk("err_quiet", 32'(err), 32'd0);
        tick();
        chk("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_rw     = '0;
        req_wdata  = {8'h44, 8'h33, 8'h22, 8'hAA};
        m_ready    = 1'b1;
        m_data_out = 8'h00;
        load_addrs();
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_men", 32'(m_enable), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_maddr", 32'(m_addr), 32'd0);
        rst = 1'b0;

        // Single write from requester 0.
        req = 4'b0001;
        chk("wr_pre_en", 32'(m_enable), 32'd0);
        tick();
        chk("wr_en", 32'(m_enable), 32'd1);
        chk("wr_addr", 32'(m_addr), 32'h2A);
        chk("wr_data", 32'(m_data_in), 32'hAA);
        chk("wr_rw", 32'(m_rw), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        addr_tab[0] = 7'h11;
        load_addrs();
        tick();
        chk("wr_hold_en", 32'(m_enable), 32'd1);
        chk("wr_latched_addr", 32'(m_addr), 32'h2A);
        m_ready = 1'b0;
        tick();
        chk("wr_busy_en", 32'(m_enable), 32'd0);
        m_ready    = 1'b1;
        m_data_out = 8'h77;
        tick();
        chk("wr_done", 32'(done), 32'b0001);
        req = '0;
        tick();
        chk("wr_done_clr", 32'(done), 32'd0);
        chk("wr_rdata_keep", 32'(rdata), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);

        // Single read from requester 2.
        req_rw = 4'b0100;
        req    = 4'b0100;
        txn(2, 8'h5C);
        req = '0;
        chk("rd_rdata", 32'(rdata), 32'h5C);

        // Requester 1 drops req mid-transaction; requester 3 arrives meanwhile.
        req_rw = '0;
        req    = 4'b0010;
        tick();
        chk("drop_addr", 32'(m_addr), 32'(addr_tab[1]));
        m_ready = 1'b0;
        tick();
        req = 4'b1000;
        tick();
        chk("drop_still_busy", 32'(busy), 32'd1);
        chk("wait_no_regrant", 32'(m_addr), 32'(addr_tab[1]));
        m_ready = 1'b1;
        tick();
        chk("drop_done", 32'(done), 32'b0010);
        tick();
        chk("after_done_idle", 32'(busy), 32'd0);
        tick();
        chk("late_grant3", 32'(m_addr), 32'(addr_tab[3]));
        chk("wr_rdata_keep2", 32'(rdata), 32'h5C);

        // Reset while requester 3 is in BUSY.
        m_ready = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_men", 32'(m_enable), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        chk("mid_rst_maddr", 32'(m_addr), 32'd0);
        m_ready = 1'b1;
        req     = 4'b1111;
        tick();
        rst = 1'b0;

        // All four held: order restarts at 0 after reset.
        for (int t = 0; t < 8; t++) txn(t % N, 8'h00);

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never accepts: watchdog fires after 16 ISSUE cycles.
        req = 4'b0011;
        tick();
        chk("to_addr0", 32'(m_addr), 32'(addr_tab[0]));
        for (int c = 0; c < 15; c++) tick();
        chk("to_still_issue", 32'(m_enable), 32'd1);
        chk("to_no_err_yet", 32'(err), 32'd0);
        tick();
        chk("to_err", 32'(err), 32'b0001);
        chk("to_no_done", 32'(done), 32'd0);
        chk("to_men_low", 32'(m_enable), 32'd0);
        req = 4'b0010;
        tick();
        chk("to_err_clr", 32'(err), 32'd0);
        txn(1, 8'h00);
        req = '0;
`else
        req = '0;
        tick();
        chk("no_err", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
